// File: rtl/lpc_pkg.sv
// Shared LPC host definitions: controller states, cycle-type nibbles and SYNC codes.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TARH,
        ST_SYNC,
        ST_RDATA,
        ST_TARP,
        ST_ABORT,
        ST_DONE
    } lpc_state_e;

    localparam logic [3:0] CYC_IO_RD  = 4'h0;
    localparam logic [3:0] CYC_IO_WR  = 4'h2;

    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_SHORT = 4'h5;
    localparam logic [3:0] SYNC_LONG  = 4'h6;
    localparam logic [3:0] SYNC_ERROR = 4'hA;
    localparam logic [3:0] SYNC_NONE  = 4'hF;

endpackage

// File: rtl/lpc_host_sync_mon.sv
// SYNC-phase monitor: decodes the peripheral's SYNC nibble and tracks wait / no-response time.
module LpcSyncMon
    import lpc_pkg::*;
#(
    parameter int unsigned NoRespMax = 3,
    parameter int unsigned WaitMax   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_active,
    input  logic [3:0] i_lad,
    output logic       o_ready,
    output logic       o_err,
    output logic       o_abort
);

    localparam int unsigned NRW = ($clog2(NoRespMax + 1) < 1) ? 1 : $clog2(NoRespMax + 1);
    localparam int unsigned WW  = ($clog2(WaitMax + 1) < 1) ? 1 : $clog2(WaitMax + 1);

    logic [NRW-1:0] r_noresp;
    logic [WW-1:0]  r_wait;
    logic           w_is_ready;
    logic           w_is_wait;
    logic           w_is_none;

    always_comb begin
        w_is_ready = (i_lad == SYNC_READY) || (i_lad == SYNC_ERROR);
        w_is_wait  = (i_lad == SYNC_SHORT) || (i_lad == SYNC_LONG);
        // unrecognised codes count as no response
        w_is_none  = !w_is_ready && !w_is_wait;
        o_ready    = i_active && w_is_ready;
        o_err      = i_active && (i_lad == SYNC_ERROR);
        o_abort    = i_active &&
                     ((w_is_wait && (32'(r_wait) + 32'd1 >= WaitMax)) ||
                      (w_is_none && (32'(r_noresp) + 32'd1 >= NoRespMax)));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_active) begin
            r_noresp <= '0;
            r_wait   <= '0;
        end else begin
            if (w_is_wait && (r_wait < WW'(WaitMax)))
                r_wait <= r_wait + WW'(1);
            if (w_is_none && (r_noresp < NRW'(NoRespMax)))
                r_noresp <= r_noresp + NRW'(1);
        end
    end

endmodule

// File: rtl/lpc_host.sv
// LPC host controller for single-byte I/O read and write cycles, with SYNC timeout abort.
module lpc_host
    import lpc_pkg::*;
#(
    parameter int unsigned NoRespMax = 3,
    parameter int unsigned WaitMax   = 255
) (
    input  logic        LpcClock,
    input  logic        PciReset,
    input  logic        Req,
    input  logic        Opcode,
    input  logic [15:0] Addr,
    input  logic [7:0]  WrData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [7:0]  RdData,
    output logic        LpcFrame,
    output logic [3:0]  LpcBusOut,
    output logic        LpcBusOe,
    input  logic [3:0]  LpcBusIn
);

    lpc_state_e  r_state;
    lpc_state_e  w_state_next;
    logic        r_op;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_shadow;
    logic [7:0]  r_rdata;
    logic        r_error;
    logic [1:0]  r_nib;
    logic [2:0]  r_abort_cnt;
    logic        w_in_sync;
    logic        w_sync_ready;
    logic        w_sync_err;
    logic        w_sync_abort;

    assign w_in_sync = (r_state == ST_SYNC);

    LpcSyncMon #(
        .NoRespMax(NoRespMax),
        .WaitMax  (WaitMax)
    ) u_sync_mon (
        .i_clk   (LpcClock),
        .i_rst   (PciReset),
        .i_active(w_in_sync),
        .i_lad   (LpcBusIn),
        .o_ready (w_sync_ready),
        .o_err   (w_sync_err),
        .o_abort (w_sync_abort)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (Req) w_state_next = ST_START;
            ST_START:   w_state_next = ST_CYCTYPE;
            ST_CYCTYPE: w_state_next = ST_ADDR;
            ST_ADDR:    if (r_nib == 2'd3) w_state_next = r_op ? ST_WDATA : ST_TARH;
            ST_WDATA:   if (r_nib == 2'd1) w_state_next = ST_TARH;
            ST_TARH:    if (r_nib == 2'd1) w_state_next = ST_SYNC;
            ST_SYNC: begin
                if (w_sync_abort)      w_state_next = ST_ABORT;
                else if (w_sync_ready) w_state_next = r_op ? ST_TARP : ST_RDATA;
            end
            ST_RDATA:   if (r_nib == 2'd1) w_state_next = ST_TARP;
            ST_TARP:    if (r_nib == 2'd1) w_state_next = ST_DONE;
            ST_ABORT:   if (r_abort_cnt == 3'd4) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        LpcFrame  = 1'b1;
        LpcBusOe  = 1'b0;
        LpcBusOut = 4'hF;
        case (r_state)
            ST_START: begin
                LpcFrame  = 1'b0;
                LpcBusOe  = 1'b1;
                LpcBusOut = 4'h0;
            end
            ST_CYCTYPE: begin
                LpcBusOe  = 1'b1;
                LpcBusOut = r_op ? CYC_IO_WR : CYC_IO_RD;
            end
            ST_ADDR: begin
                LpcBusOe = 1'b1;
                case (r_nib)
                    2'd0:    LpcBusOut = r_addr[15:12];
                    2'd1:    LpcBusOut = r_addr[11:8];
                    2'd2:    LpcBusOut = r_addr[7:4];
                    default: LpcBusOut = r_addr[3:0];
                endcase
            end
            ST_WDATA: begin
                LpcBusOe  = 1'b1;
                LpcBusOut = (r_nib == 2'd0) ? r_wdata[3:0] : r_wdata[7:4];
            end
            ST_TARH:  LpcBusOe = (r_nib == 2'd0);
            // fifth abort clock releases LFRAME# and LAD before DONE
            ST_ABORT: begin
                if (r_abort_cnt < 3'd4) begin
                    LpcFrame = 1'b0;
                    LpcBusOe = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign Done   = (r_state == ST_DONE);
    assign Error  = r_error;
    assign RdData = r_rdata;

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            r_state     <= ST_IDLE;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_shadow    <= '0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
            r_nib       <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_nib       <= (w_state_next != r_state) ? 2'd0 : r_nib + 2'd1;
            r_abort_cnt <= (r_state == ST_ABORT) ? r_abort_cnt + 3'd1 : 3'd0;
            if (r_state == ST_IDLE && Req) begin
                r_op    <= Opcode;
                r_addr  <= Addr;
                r_wdata <= WrData;
                r_error <= 1'b0;
            end
            if (w_in_sync && (w_sync_err || w_sync_abort))
                r_error <= 1'b1;
            if (r_state == ST_RDATA) begin
                if (r_nib == 2'd0) r_shadow[3:0] <= LpcBusIn;
                else               r_shadow[7:4] <= LpcBusIn;
            end
            // RdData becomes visible together with the Done pulse
            if (r_state == ST_TARP && w_state_next == ST_DONE && !r_op && !r_error)
                r_rdata <= r_shadow;
        end
    end

endmodule
